// File: rtl/dec_scan_seq.sv
// Registered one-hot decoder with a built-in scan sequencer: direct decode,
// continuous walking-one scan, and a triggered single sweep with busy/wrap status.
module dec_scan_seq #(
   parameter int N = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [N-1:0]        i_w,
   input  logic                i_e,
   input  logic [1:0]          i_mode,
   input  logic                i_dir,
   input  logic                i_start,
   output logic [(1<<N)-1:0]   o_y,
   output logic [N-1:0]        o_idx,
   output logic                o_busy,
   output logic                o_wrap
);

   localparam int W = 1 << N;
   localparam logic [N-1:0] C_MAX  = {N{1'b1}};
   localparam logic [N-1:0] C_ZERO = '0;

   typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_mode_prev;
   logic [N-1:0]  r_cnt, w_cnt_nxt;
   logic [N-1:0]  r_idx, w_idx_nxt;
   logic          r_sweep_dir, w_sweep_dir_nxt;
   logic [W-1:0]  r_y, w_y_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_wrap, w_wrap_nxt;

   function automatic logic [W-1:0] f_onehot(input logic [N-1:0] a);
      return W'(1) << a;
   endfunction

   function automatic logic [N-1:0] f_step(input logic [N-1:0] a, input logic d);
      return d ? a - N'(1) : a + N'(1);
   endfunction

   function automatic logic f_is_term(input logic [N-1:0] a, input logic d);
      return d ? (a == C_ZERO) : (a == C_MAX);
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_mode_prev <= 2'b00;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_sweep_dir <= 1'b0;
         r_y         <= '0;
         r_busy      <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_prev <= i_mode;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_sweep_dir <= w_sweep_dir_nxt;
         r_y         <= w_y_nxt;
         r_busy      <= w_busy_nxt;
         r_wrap      <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_idx_nxt       = r_idx;
      w_sweep_dir_nxt = r_sweep_dir;
      w_y_nxt         = '0;
      w_busy_nxt      = 1'b0;
      w_wrap_nxt      = 1'b0;

      // A mode change costs one blank cycle; the new mode starts on the next edge.
      if (i_mode != r_mode_prev) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (i_mode)
            2'b00: begin
               w_state_nxt = S_IDLE;
               if (i_e) begin
                  w_y_nxt   = f_onehot(i_w);
                  w_idx_nxt = i_w;
               end
            end
            2'b01: begin
               w_state_nxt = S_IDLE;
               if (i_e) begin
                  w_y_nxt    = f_onehot(r_cnt);
                  w_idx_nxt  = r_cnt;
                  w_cnt_nxt  = f_step(r_cnt, i_dir);
                  w_wrap_nxt = f_is_term(r_cnt, i_dir);
               end
            end
            2'b10: begin
               case (r_state)
                  S_IDLE: begin
                     if (i_start) begin
                        w_cnt_nxt       = i_dir ? C_MAX : C_ZERO;
                        w_sweep_dir_nxt = i_dir;
                        w_state_nxt     = S_SWEEP;
                        w_busy_nxt      = 1'b1;
                     end
                  end
                  S_SWEEP: begin
                     w_busy_nxt = 1'b1;
                     if (i_e) begin
                        w_y_nxt   = f_onehot(r_cnt);
                        w_idx_nxt = r_cnt;
                        w_cnt_nxt = f_step(r_cnt, r_sweep_dir);
                        if (f_is_term(r_cnt, r_sweep_dir)) begin
                           w_wrap_nxt  = 1'b1;
                           w_busy_nxt  = 1'b0;
                           w_state_nxt = S_IDLE;
                        end
                     end
                  end
                  default: w_state_nxt = S_IDLE;
               endcase
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign o_y    = r_y;
   assign o_idx  = r_idx;
   assign o_busy = r_busy;
   assign o_wrap = r_wrap;

endmodule
